// File: rtl/uart_led_cmd.sv
`default_nettype none
// ============================================================================
// Module      : uart_led_cmd
// Description : Text command parser on a simpleuart register port ("R80\r")
//               driving three glitch-free 8-bit PWM LED channels.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_led_cmd #(
    parameter int PWM_DIV = 47
) (
    input  logic        hw_clk,
    input  logic        resetn,
    input  logic [31:0] reg_dat_do,
    input  logic        reg_dat_wait,
    output logic        reg_dat_re,
    output logic        reg_dat_we,
    output logic [31:0] reg_dat_di,
    output logic [7:0]  duty_red,
    output logic [7:0]  duty_green,
    output logic [7:0]  duty_blue,
    output logic        pwm_red,
    output logic        pwm_green,
    output logic        pwm_blue
);

    localparam int             c_PRESC_W = (PWM_DIV > 0) ? $clog2(PWM_DIV + 1) : 1;
    localparam logic [c_PRESC_W-1:0] c_DIV_MAX = c_PRESC_W'(PWM_DIV);
    localparam logic [7:0]     c_CH_K    = 8'h4B;
    localparam logic [7:0]     c_CH_E    = 8'h45;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_HEX_HI = 3'd2,
        ST_HEX_LO = 3'd3,
        ST_EOL    = 3'd4,
        ST_TX     = 3'd5
    } state_t;

    state_t      state_q, state_d;
    state_t      phase_q, phase_d;
    logic [7:0]  byte_q, byte_d;
    logic        re_q, re_d, re_dly_q;
    logic        we_q, we_d;
    logic [7:0]  di_q, di_d;
    logic [1:0]  sel_q, sel_d;
    logic [7:0]  stage_q, stage_d;
    logic [7:0]  shr_q, shr_d, shg_q, shg_d, shb_q, shb_d;

    logic [c_PRESC_W-1:0] presc_q;
    logic [7:0]  cnt_q;
    logic [7:0]  duty_r_q, duty_g_q, duty_b_q;
    logic        pwm_r_q, pwm_g_q, pwm_b_q;
    logic        tick, wrap;

    logic        rx_ok, is_eol, reply_err, reply_ok;
    logic [4:0]  nib;

    logic        unused_do;
    assign unused_do = &{1'b0, reg_dat_do[30:8]};

    // {valid, nibble} for an ASCII hex digit
    function automatic logic [4:0] hex_nib(input logic [7:0] c);
        logic [4:0] r;
        r = 5'd0;
        if (c >= 8'h30 && c <= 8'h39)      r = {1'b1, c[3:0]};
        else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
                                           r = {1'b1, 4'(c[3:0] + 4'd9)};
        return r;
    endfunction

    // The UART data register is stale for one cycle after a consume pulse.
    assign rx_ok  = !re_q && !re_dly_q && !reg_dat_do[31];
    assign is_eol = (byte_q == 8'h0D) || (byte_q == 8'h0A);
    assign nib    = hex_nib(byte_q);

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        byte_d    = byte_q;
        re_d      = 1'b0;
        we_d      = we_q;
        di_d      = di_q;
        sel_d     = sel_q;
        stage_d   = stage_q;
        shr_d     = shr_q;
        shg_d     = shg_q;
        shb_d     = shb_q;
        reply_err = 1'b0;
        reply_ok  = 1'b0;

        case (state_q)
            ST_IDLE, ST_HEX_HI, ST_HEX_LO, ST_EOL: begin
                if (rx_ok) begin
                    byte_d  = reg_dat_do[7:0];
                    re_d    = 1'b1;
                    phase_d = state_q;
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                case (phase_q)
                    ST_IDLE: begin
                        case (byte_q)
                            8'h52, 8'h72: begin sel_d = 2'd0; state_d = ST_HEX_HI; end
                            8'h47, 8'h67: begin sel_d = 2'd1; state_d = ST_HEX_HI; end
                            8'h42, 8'h62: begin sel_d = 2'd2; state_d = ST_HEX_HI; end
                            8'h0D, 8'h0A: state_d = ST_IDLE;
                            default:      reply_err = 1'b1;
                        endcase
                    end
                    ST_HEX_HI: begin
                        if (nib[4]) begin
                            stage_d[7:4] = nib[3:0];
                            state_d      = ST_HEX_LO;
                        end else begin
                            reply_err = 1'b1;
                        end
                    end
                    ST_HEX_LO: begin
                        if (nib[4]) begin
                            stage_d[3:0] = nib[3:0];
                            state_d      = ST_EOL;
                        end else begin
                            reply_err = 1'b1;
                        end
                    end
                    ST_EOL: begin
                        if (is_eol) begin
                            reply_ok = 1'b1;
                            case (sel_q)
                                2'd0:    shr_d = stage_q;
                                2'd1:    shg_d = stage_q;
                                default: shb_d = stage_q;
                            endcase
                        end else begin
                            reply_err = 1'b1;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
            ST_TX: begin
                if (we_q && !reg_dat_wait) begin
                    we_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (reply_err) begin
            stage_d = 8'd0;
            di_d    = c_CH_E;
            we_d    = 1'b1;
            state_d = ST_TX;
        end else if (reply_ok) begin
            di_d    = c_CH_K;
            we_d    = 1'b1;
            state_d = ST_TX;
        end
    end

    always_ff @(posedge hw_clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            phase_q  <= ST_IDLE;
            byte_q   <= 8'd0;
            re_q     <= 1'b0;
            re_dly_q <= 1'b0;
            we_q     <= 1'b0;
            di_q     <= 8'd0;
            sel_q    <= 2'd0;
            stage_q  <= 8'd0;
            shr_q    <= 8'd0;
            shg_q    <= 8'd0;
            shb_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            byte_q   <= byte_d;
            re_q     <= re_d;
            re_dly_q <= re_q;
            we_q     <= we_d;
            di_q     <= di_d;
            sel_q    <= sel_d;
            stage_q  <= stage_d;
            shr_q    <= shr_d;
            shg_q    <= shg_d;
            shb_q    <= shb_d;
        end
    end

    assign tick = (presc_q == c_DIV_MAX);
    assign wrap = tick && (cnt_q == 8'hFF);

    // Duty loads only at frame wrap, so a running period is never cut short.
    always_ff @(posedge hw_clk or negedge resetn) begin
        if (!resetn) begin
            presc_q  <= '0;
            cnt_q    <= 8'd0;
            duty_r_q <= 8'd0;
            duty_g_q <= 8'd0;
            duty_b_q <= 8'd0;
            pwm_r_q  <= 1'b0;
            pwm_g_q  <= 1'b0;
            pwm_b_q  <= 1'b0;
        end else begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (wrap) begin
                duty_r_q <= shr_q;
                duty_g_q <= shg_q;
                duty_b_q <= shb_q;
            end
            pwm_r_q <= (cnt_q < duty_r_q);
            pwm_g_q <= (cnt_q < duty_g_q);
            pwm_b_q <= (cnt_q < duty_b_q);
        end
    end

    assign reg_dat_re = re_q;
    assign reg_dat_we = we_q;
    assign reg_dat_di = {24'd0, di_q};
    assign duty_red   = duty_r_q;
    assign duty_green = duty_g_q;
    assign duty_blue  = duty_b_q;
    assign pwm_red    = pwm_r_q;
    assign pwm_green  = pwm_g_q;
    assign pwm_blue   = pwm_b_q;

endmodule
`default_nettype wire
